// File: rtl/pc_fetch_reg.sv
// Program-counter register stage.
// Holds the current PC and offers it to the fetch stage over a valid/ready
// handshake. Three states:
//   BOOT - a programmable hold-off after reset.
//   RUN  - the PC steps on each accepted fetch, or loads a redirect target.
//   HALT - entered on a misaligned redirect; it is sticky until RST.
// Handshake: a fetch completes on a rising edge where pc_valid=1,
// fetch_ready=1 and ena=1. pc_out stays stable while pc_valid=1 and
// fetch_ready=0. All outputs come straight from registers.
module pc_fetch_reg #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int               STEP         = 4,
   parameter int               BOOT_CYCLES  = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ena,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_addr,
   input  logic             fetch_ready,
   output logic [WIDTH-1:0] pc_out,
   output logic             pc_valid,
   output logic             misaligned,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      S_BOOT = 2'b00,
      S_RUN  = 2'b01,
      S_HALT = 2'b10
   } state_t;

   localparam int               CW        = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam logic [CW-1:0]    BOOT_INIT = CW'(BOOT_CYCLES - 1);
   localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic             valid_q, valid_d;
   logic             mis_q, mis_d;
   logic             redir_bad;

   // A redirect target that is not word aligned stops the stage.
   assign redir_bad = redirect_valid && (redirect_addr[1:0] != 2'b00);

   // Next-state logic. When ena is low, every register keeps its value.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      mis_d   = mis_q;
      if (ena) begin
         case (state_q)
            S_BOOT: begin
               if (redir_bad) begin
                  state_d = S_HALT;
                  valid_d = 1'b0;
                  mis_d   = 1'b1;
               end else begin
                  // A redirect during BOOT loads the PC but does not shorten the hold-off.
                  if (redirect_valid) begin
                     pc_d = redirect_addr;
                  end
                  if (cnt_q == '0) begin
                     state_d = S_RUN;
                     valid_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q - 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (redir_bad) begin
                  state_d = S_HALT;
                  valid_d = 1'b0;
                  mis_d   = 1'b1;
               end else if (redirect_valid) begin
                  // The redirect wins even when the current PC is consumed on this edge.
                  pc_d = redirect_addr;
               end else if (valid_q && fetch_ready) begin
                  pc_d = pc_q + STEP_W;
               end
            end
            S_HALT: begin
               // Only RST leaves HALT.
            end
            default: begin
               state_d = S_HALT;
               valid_d = 1'b0;
               mis_d   = 1'b1;
            end
         endcase
      end
   end

   // State register with an asynchronous reset that forces the boot state at once.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_BOOT;
         cnt_q   <= BOOT_INIT;
         pc_q    <= RESET_VECTOR;
         valid_q <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         mis_q   <= mis_d;
      end
   end

   assign pc_out     = pc_q;
   assign pc_valid   = valid_q;
   assign misaligned = mis_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_pc_fetch_reg.sv
// Testbench for pc_fetch_reg.
// The driver issues one cycle of stimulus, steps a behavioural model of the
// PC stage, and queues the expected outputs. A monitor on the falling edge
// pops each expectation and compares it against the DUT outputs.
module tb_pc_fetch_reg;

  localparam int          WIDTH       = 32;
  localparam int          STEP        = 4;
  localparam int          BOOT_CYCLES = 2;
  localparam logic [31:0] RV          = 32'h0000_0000;
  localparam int          EW          = WIDTH + 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             ena;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_addr;
  logic             fetch_ready;
  logic [WIDTH-1:0] pc_out;
  logic             pc_valid;
  logic             misaligned;
  logic [1:0]       state_dbg;

  pc_fetch_reg #(
    .WIDTH(WIDTH), .RESET_VECTOR(RV), .STEP(STEP), .BOOT_CYCLES(BOOT_CYCLES)
  ) dut (
    .CLK(CLK), .RST(RST), .ena(ena),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .fetch_ready(fetch_ready),
    .pc_out(pc_out), .pc_valid(pc_valid), .misaligned(misaligned),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // The model tracks the PC, whether a PC is on offer, the sticky halt flag,
  // and how many enabled edges of boot delay are left.
  logic [WIDTH-1:0] m_pc;
  bit               m_valid;
  bit               m_mis;
  int               m_boot_left;

  function automatic logic [EW-1:0] model_out();
    logic [1:0] st;
    st = m_mis ? 2'b10 : (m_valid ? 2'b01 : 2'b00);
    return {m_pc, m_valid, m_mis, st};
  endfunction

  task automatic model_reset();
    m_pc        = RV;
    m_valid     = 1'b0;
    m_mis       = 1'b0;
    m_boot_left = BOOT_CYCLES;
  endtask

  task automatic model_step(input bit e, input bit rv, input logic [WIDTH-1:0] addr, input bit fr);
    if (!e || m_mis) return;
    if (rv && addr[1:0] != 2'b00) begin
      m_mis   = 1'b1;
      m_valid = 1'b0;
      return;
    end
    if (!m_valid) begin
      m_boot_left = m_boot_left - 1;
      if (rv) m_pc = addr;
      if (m_boot_left == 0) m_valid = 1'b1;
    end else if (rv) begin
      m_pc = addr;
    end else if (fr) begin
      m_pc = m_pc + 32'(STEP);
    end
  endtask

  // ---------------- scoreboard compare ----------------
  task automatic check_out(input string name, input logic [EW-1:0] exp);
    logic [EW-1:0] act;
    act = {pc_out, pc_valid, misaligned, state_dbg};
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got pc=%h valid=%b mis=%b st=%b, expected pc=%h valid=%b mis=%b st=%b",
               name, $time, act[EW-1:4], act[3], act[2], act[1:0],
               exp[EW-1:4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  // The monitor compares on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) check_out("scoreboard", exp_q.pop_front());
  end

  // ---------------- driver tasks ----------------
  // Drive one cycle. The call is made just after a falling edge and returns
  // on the next falling edge. The expectation is queued after the rising
  // edge, so the monitor never sees an expectation early.
  task automatic drive(input bit e, input bit rv, input logic [WIDTH-1:0] addr, input bit fr);
    ena            = e;
    redirect_valid = rv;
    redirect_addr  = addr;
    fetch_ready    = fr;
    model_step(e, rv, addr, fr);
    @(posedge CLK);
    exp_q.push_back(model_out());
    @(negedge CLK);
  endtask

  // Assert RST between edges. Reset must act before the next rising edge.
  task automatic apply_reset();
    #2;
    RST            = 1'b1;
    ena            = 1'b0;
    redirect_valid = 1'b0;
    fetch_ready    = 1'b0;
    model_reset();
    #1;
    check_out("async_reset", model_out());
    @(negedge CLK);
    check_out("reset_hold", model_out());
    RST = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] a;
    RST            = 1'b0;
    ena            = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    fetch_ready    = 1'b0;
    model_reset();
    @(negedge CLK);

    // Boot sequence, then free-running fetches.
    apply_reset();
    repeat (5) drive(1, 0, '0, 1);

    // Backpressure at 0x10.
    drive(1, 1, 32'h10, 0);
    repeat (3) drive(1, 0, '0, 0);
    repeat (2) drive(1, 0, '0, 1);

    // A redirect wins over an accepted fetch on the same edge.
    drive(1, 1, 32'h20, 0);
    drive(1, 1, 32'h100, 1);
    repeat (2) drive(1, 0, '0, 1);

    // A misaligned redirect halts the stage; later activity is ignored.
    drive(1, 1, 32'h102, 1);
    drive(1, 1, 32'h200, 1);
    repeat (2) drive(1, 0, '0, 1);
    apply_reset();
    repeat (3) drive(1, 0, '0, 1);

    // Wrap at the top of the address space, then freeze with ena=0.
    drive(1, 1, 32'hFFFF_FFFC, 0);
    drive(1, 0, '0, 1);
    drive(0, 0, '0, 1);
    drive(0, 1, 32'h300, 1);
    drive(1, 0, '0, 1);

    // A misaligned redirect during BOOT halts the stage; ena=0 freezes BOOT.
    apply_reset();
    drive(0, 0, '0, 1);
    drive(1, 1, 32'h7, 1);
    repeat (2) drive(1, 0, '0, 1);

    // An aligned redirect during BOOT loads the PC without shortening BOOT.
    apply_reset();
    drive(1, 1, 32'h80, 1);
    repeat (3) drive(1, 0, '0, 1);

    // Asynchronous reset mid-run at 0x40.
    apply_reset();
    repeat (2) drive(1, 0, '0, 0);
    drive(1, 1, 32'h40, 0);
    drive(1, 0, '0, 0);
    apply_reset();
    repeat (3) drive(1, 0, '0, 1);

    // Randomized runs, each starting from reset.
    repeat (8) begin
      apply_reset();
      repeat (60) begin
        a = $urandom;
        if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFF0;
        if ($urandom_range(0, 11) != 0) a[1:0] = 2'b00;
        drive($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, a,
              $urandom_range(0, 3) != 0);
      end
    end

    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch_reg.md
Name: pc_fetch_reg

Overview:
Program-counter register stage built on the edge-triggered register primitives from the trigger experiments. It holds the current PC and presents it to the downstream instruction-fetch stage over a valid/ready handshake. It advances by a fixed step on each accepted fetch and accepts branch/jump redirects from upstream. After reset it holds off for a programmable boot delay. It halts with a sticky flag on a misaligned redirect.

Parameters:
WIDTH, 32, PC width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
STEP, 4, increment applied per accepted fetch
BOOT_CYCLES, 2, cycles spent in BOOT before the first pc_valid (>=1)

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST  input  1  asynchronous, active-high reset
ena  input  1  global enable; 0 freezes all state and outputs
redirect_valid  input  1  upstream requests PC load this cycle
redirect_addr  input  WIDTH  target address for redirect
fetch_ready  input  1  downstream fetch stage accepts pc_out this cycle
pc_out  output  WIDTH  current PC presented to fetch
pc_valid  output  1  pc_out is valid for fetch
misaligned  output  1  sticky; a redirect target had addr[1:0] != 0
state_dbg  output  2  encoded FSM state (00 BOOT, 01 RUN, 10 HALT)

Behaviour:
- Reset: RST=1 forces the following immediately, without waiting for a clock edge: pc_out=RESET_VECTOR, pc_valid=0, misaligned=0, state=BOOT, boot counter=BOOT_CYCLES-1. Reset asserted mid-operation overrides everything.
- All outputs are registered. There is no combinational path from inputs to outputs.
- ena=0: no register changes. pc_valid and pc_out hold. Handshakes and redirects in that cycle are ignored and not queued.
- BOOT, with ena=1: the counter decrements each edge.
  - At counter 0, the next edge goes to RUN and sets pc_valid=1.
  - First pc_valid rises BOOT_CYCLES edges after RST deasserts.
  - redirect_valid in BOOT loads pc_out with the target and does not shorten BOOT. The misalignment check still applies.
- RUN, per edge with ena=1, in priority order:
  1. redirect_valid=1, addr[1:0]!=0: state goes to HALT, pc_valid goes to 0, misaligned goes to 1, pc_out is unchanged.
  2. redirect_valid=1, aligned: pc_out goes to redirect_addr and pc_valid stays 1. An unaccepted current PC is discarded. If fetch_ready is also high, the old PC counts as consumed, but the redirect still wins the next value.
  3. pc_valid && fetch_ready: pc_out goes to pc_out+STEP.
  4. Otherwise pc_out holds. It must stay stable while pc_valid=1 and fetch_ready=0.
- Arithmetic: increment is modulo 2^WIDTH. From {WIDTH{1'b1}}-3 with STEP=4, pc_out wraps to 0 with no flag.
- HALT: pc_valid=0 and misaligned=1 are held. Redirects and fetch_ready are ignored. Only RST exits HALT.
- Latency: a redirect sampled at edge N is visible on pc_out after edge N. The first fetch of the target can therefore complete at edge N+1.

Test Plan:
- Reset/boot: BOOT_CYCLES=2, RST 1 then 0, ena=1, fetch_ready=1 → pc_valid=0 for 2 edges, then 1 with pc_out=0x0; pc_out then reads 0x4 and 0x8 on successive edges.
- Backpressure: in RUN at pc_out=0x10, fetch_ready=0 for 3 cycles → pc_out stays 0x10 and pc_valid=1; fetch_ready=1 → next edge pc_out=0x14.
- Redirect priority: pc_out=0x20, redirect_valid=1 with addr=0x100 and fetch_ready=1 on the same edge → pc_out=0x100 (not 0x24); next accepted edge gives 0x104.
- Misaligned redirect: redirect addr=0x102 → misaligned=1, pc_valid=0, state_dbg=10, pc_out unchanged. Further redirects and fetch_ready have no effect until RST, which clears misaligned and returns to BOOT.
- Wrap and enable: pc_out=0xFFFF_FFFC, fetch_ready=1 → 0x0000_0000. With ena=0 and fetch_ready=1 over 2 edges, pc_out is frozen.
- Async reset mid-run: assert RST between clock edges at pc_out=0x40 → pc_out=0x0 and pc_valid=0 before the next CLK rise.
